// File: rtl/mac_pkg.sv
// Shared MAC constants and decoder state encoding, used by both the RX decoder and the TX encoder.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DEST,
        S_SOURCE,
        S_TYPE,
        S_PAYLOAD,
        S_DROP
    } mac_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [10:0] DEST_LEN      = 11'd6;
    localparam logic [10:0] SRC_LEN       = 11'd6;
    localparam logic [10:0] TYPE_LEN      = 11'd2;

    localparam logic [10:0] MIN_FRAME     = 11'd64;
    localparam logic [10:0] MAX_FRAME     = 11'd1518;

    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == '1) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/mac_decode_crc32.sv
// Ethernet CRC-32 (reflected, LSB-first), WIDTH bits per enabled clock; register is not inverted.
module crc32
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [31:0]      crc
);

    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (crc_next[0] ^ data[i])
                crc_next = (crc_next >> 1) ^ CRC_POLY;
            else
                crc_next = crc_next >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc_next;
    end

endmodule

// File: rtl/mac_decode.sv
// Receive MAC decoder: preamble/SFD strip, header capture, payload streaming with FCS hidden, verdict.
// Optional destination filter enabled by defining MAC_RX_ADDR_FILTER_EN.
module mac_decode
    import mac_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'hdeadbeefcafe
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mac_phy_rxdv,
    input  logic        mac_phy_rxer,
    input  logic [7:0]  mac_phy_rxd,
    output logic [47:0] mac_src,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  payload,
    output logic        payload_valid,
    output logic        payload_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_fcs,
    output logic        err_len,
    output logic        err_phy
);

    localparam logic [2:0] PEND_FULL = 3'd5;

    mac_state_t      state;
    logic [10:0]     cnt;
    logic [2:0]      fill;
    logic [3:0][7:0] dly;
    logic [7:0]      pend;
    logic [47:0]     src_sh;
    logic [7:0]      type_hi;
    logic            phy_seen;
    logic            oversize;
    logic [31:0]     crc;
    logic            crc_en;
    logic            crc_init;
    logic            fcs_bad;
    logic            len_bad;

`ifdef MAC_RX_ADDR_FILTER_EN
    logic [39:0]     dest_sh;
    logic            dest_hit;

    always_comb begin
        dest_hit = ({dest_sh, mac_phy_rxd} == MAC_ADDR) || ({dest_sh, mac_phy_rxd} == '1);
    end
`endif

    always_comb begin
        crc_init = (state == S_PREAMBLE) && mac_phy_rxdv && (mac_phy_rxd == SFD_BYTE);
        crc_en   = mac_phy_rxdv && ((state == S_DEST) || (state == S_SOURCE) ||
                                    (state == S_TYPE) || (state == S_PAYLOAD) ||
                                    ((state == S_DROP) && oversize));
        fcs_bad  = (crc != CRC_RESIDUE);
        len_bad  = (cnt < MIN_FRAME) || (cnt > MAX_FRAME);
    end

    crc32 #(.WIDTH(8)) u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (mac_phy_rxd),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            fill          <= '0;
            dly           <= '0;
            pend          <= '0;
            src_sh        <= '0;
            type_hi       <= '0;
            phy_seen      <= 1'b0;
            oversize      <= 1'b0;
            mac_src       <= '0;
            ethertype     <= '0;
            hdr_valid     <= 1'b0;
            payload       <= '0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_fcs       <= 1'b0;
            err_len       <= 1'b0;
            err_phy       <= 1'b0;
`ifdef MAC_RX_ADDR_FILTER_EN
            dest_sh       <= '0;
`endif
        end else begin
            hdr_valid     <= 1'b0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            frame_done    <= 1'b0;

            case (state)
                S_IDLE: begin
                    oversize <= 1'b0;
                    if (mac_phy_rxdv)
                        state <= (mac_phy_rxd == PREAMBLE_BYTE) ? S_PREAMBLE : S_DROP;
                end

                S_PREAMBLE: begin
                    if (!mac_phy_rxdv) begin
                        state <= S_IDLE;
                    end else if (mac_phy_rxd == SFD_BYTE) begin
                        state    <= S_DEST;
                        cnt      <= '0;
                        fill     <= '0;
                        phy_seen <= mac_phy_rxer;
                        oversize <= 1'b0;
                    end else if (mac_phy_rxd != PREAMBLE_BYTE) begin
                        state <= S_DROP;
                    end
                end

                S_DEST, S_SOURCE, S_TYPE: begin
                    if (!mac_phy_rxdv) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        err_len    <= 1'b1;
                        err_fcs    <= fcs_bad;
                        err_phy    <= phy_seen;
                        state      <= S_IDLE;
                    end else begin
                        cnt      <= sat_inc(cnt);
                        phy_seen <= phy_seen | mac_phy_rxer;
                        if (state == S_DEST) begin
`ifdef MAC_RX_ADDR_FILTER_EN
                            dest_sh <= {dest_sh[31:0], mac_phy_rxd};
                            if (cnt == DEST_LEN - 11'd1)
                                state <= dest_hit ? S_SOURCE : S_DROP;
`else
                            if (cnt == DEST_LEN - 11'd1)
                                state <= S_SOURCE;
`endif
                        end else if (state == S_SOURCE) begin
                            src_sh <= {src_sh[39:0], mac_phy_rxd};
                            if (cnt == DEST_LEN + SRC_LEN - 11'd1)
                                state <= S_TYPE;
                        end else if (cnt == DEST_LEN + SRC_LEN) begin
                            type_hi <= mac_phy_rxd;
                        end else if (cnt == DEST_LEN + SRC_LEN + TYPE_LEN - 11'd1) begin
                            mac_src   <= src_sh;
                            ethertype <= {type_hi, mac_phy_rxd};
                            hdr_valid <= 1'b1;
                            state     <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (!mac_phy_rxdv) begin
                        // Whatever is still in the 4-byte delay line is the FCS and is discarded.
                        if (fill == PEND_FULL) begin
                            payload       <= pend;
                            payload_valid <= 1'b1;
                            payload_last  <= 1'b1;
                        end
                        frame_done <= 1'b1;
                        err_fcs    <= fcs_bad;
                        err_len    <= len_bad;
                        err_phy    <= phy_seen;
                        frame_ok   <= !(fcs_bad || len_bad || phy_seen);
                        state      <= S_IDLE;
                    end else begin
                        cnt      <= sat_inc(cnt);
                        phy_seen <= phy_seen | mac_phy_rxer;
                        if (cnt >= MAX_FRAME) begin
                            oversize <= 1'b1;
                            state    <= S_DROP;
                        end else begin
                            if (fill == PEND_FULL) begin
                                payload       <= pend;
                                payload_valid <= 1'b1;
                            end else begin
                                fill <= fill + 3'd1;
                            end
                            pend <= dly[3];
                            dly  <= {dly[2:0], mac_phy_rxd};
                        end
                    end
                end

                S_DROP: begin
                    if (!mac_phy_rxdv) begin
                        if (oversize) begin
                            frame_done <= 1'b1;
                            frame_ok   <= 1'b0;
                            err_len    <= 1'b1;
                            err_fcs    <= fcs_bad;
                            err_phy    <= phy_seen;
                        end
                        oversize <= 1'b0;
                        state    <= S_IDLE;
                    end else if (oversize) begin
                        cnt      <= sat_inc(cnt);
                        phy_seen <= phy_seen | mac_phy_rxer;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
